// File: rtl/vga_image_overlay.sv
// Image overlay stage for the VGA pixel pipeline.
// Draws a grayscale image from a dual-buffered BRAM, upscaled by 2^SCALE_LOG2,
// inside a 1-pixel white border on a solid background. Sync and enable are
// delayed by the same MEM_LAT+2 cycles as the colour data.
module vga_image_overlay #(
  parameter int         WIDTH      = 12,
  parameter int         IMG_W      = 28,
  parameter int         IMG_H      = 28,
  parameter int         SCALE_LOG2 = 3,
  parameter int         X0         = 100,
  parameter int         Y0         = 50,
  parameter int         ADDR_W     = 11,
  parameter int         MEM_LAT    = 1,
  parameter logic [7:0] BG_COLOR   = 8'h00,
  parameter bit         HSPP       = 1'b1,
  parameter bit         VSPP       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  hdata,
  input  logic [WIDTH-1:0]  vdata,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              buf_sel,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              de_out,
  output logic [2:0]        red,
  output logic [2:0]        green,
  output logic [1:0]        blue
);

  localparam int IDX_W = ADDR_W - 1;
  localparam int WIN_W = IMG_W << SCALE_LOG2;
  localparam int WIN_H = IMG_H << SCALE_LOG2;

  // Window bounds: *_LO is the first pixel inside, *_HI the first pixel past it.
  localparam logic [WIDTH-1:0] X_LO = WIDTH'(X0);
  localparam logic [WIDTH-1:0] X_HI = WIDTH'(X0 + WIN_W);
  localparam logic [WIDTH-1:0] Y_LO = WIDTH'(Y0);
  localparam logic [WIDTH-1:0] Y_HI = WIDTH'(Y0 + WIN_H);

  // Border ring; a window touching the screen edge has no left/top ring line.
  localparam bit               HAS_L = (X0 > 0);
  localparam bit               HAS_T = (Y0 > 0);
  localparam logic [WIDTH-1:0] BX_LO = HAS_L ? WIDTH'(X0 - 1) : {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] BY_LO = HAS_T ? WIDTH'(Y0 - 1) : {WIDTH{1'b0}};

  // Pipeline word layout: {in_win, on_border, de, hsync, vsync}.
  localparam int F_WIN = 4;
  localparam int F_BRD = 3;
  localparam int F_DE  = 2;
  localparam int F_HS  = 1;
  localparam int F_VS  = 0;
  localparam logic [4:0] PIPE_IDLE = {1'b0, 1'b0, 1'b0, ~HSPP, ~VSPP};

  logic              in_win_s;
  logic              on_border_s;
  logic              x_edge_s;
  logic              y_edge_s;
  logic              x_span_s;
  logic              y_span_s;
  logic [WIDTH-1:0]  dx_s;
  logic [WIDTH-1:0]  dy_s;
  logic [IDX_W-1:0]  col_s;
  logic [IDX_W-1:0]  row_s;
  logic [IDX_W-1:0]  idx_s;
  logic              frame_start_s;
  logic [4:0]        tap_s;
  logic [7:0]        rgb_s;
  logic              unused_s;

  logic [ADDR_W-1:0] mem_addr_r;
  logic [4:0]        stg_a_r;
  logic [4:0]        dly_r [MEM_LAT];
  logic [7:0]        rgb_r;
  logic              de_r;
  logic              hs_r;
  logic              vs_r;
  logic              buf_sel_r;
  logic              swap_ack_r;

  // Only the top three grey bits reach the 3-3-2 colour output.
  assign unused_s = ^mem_rdata[4:0];

  // Window test, image coordinates and border ring for the incoming pixel.
  always_comb begin
    in_win_s = (hdata >= X_LO) && (hdata < X_HI) && (vdata >= Y_LO) && (vdata < Y_HI);
    if (in_win_s) begin
      dx_s = hdata - X_LO;
      dy_s = vdata - Y_LO;
    end else begin
      dx_s = {WIDTH{1'b0}};
      dy_s = {WIDTH{1'b0}};
    end
    col_s       = IDX_W'(dx_s >> SCALE_LOG2);
    row_s       = IDX_W'(dy_s >> SCALE_LOG2);
    idx_s       = row_s * IDX_W'(IMG_W) + col_s;
    x_edge_s    = (HAS_L && (hdata == BX_LO)) || (hdata == X_HI);
    y_edge_s    = (HAS_T && (vdata == BY_LO)) || (vdata == Y_HI);
    x_span_s    = (hdata >= BX_LO) && (hdata <= X_HI);
    y_span_s    = (vdata >= BY_LO) && (vdata <= Y_HI);
    on_border_s = (x_edge_s && y_span_s) || (y_edge_s && x_span_s);
  end

  // Stage A: issue the BRAM read and capture the per-pixel control bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_r <= {ADDR_W{1'b0}};
      stg_a_r    <= PIPE_IDLE;
    end else begin
      mem_addr_r <= {buf_sel_r, (in_win_s ? idx_s : {IDX_W{1'b0}})};
      stg_a_r    <= {in_win_s, on_border_s, de_in, hsync_in, vsync_in};
    end
  end

  // Delay line that tracks the BRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) dly_r[i] <= PIPE_IDLE;
    end else begin
      dly_r[0] <= stg_a_r;
      for (int i = 1; i < MEM_LAT; i++) dly_r[i] <= dly_r[i-1];
    end
  end

  assign tap_s = dly_r[MEM_LAT-1];

  // Colour selection: blanking, then image, then border, then background.
  always_comb begin
    rgb_s = 8'h00;
    if (!tap_s[F_DE]) begin
      rgb_s = 8'h00;
    end else if (tap_s[F_WIN]) begin
      rgb_s = {mem_rdata[7:5], mem_rdata[7:5], mem_rdata[7:6]};
    end else if (tap_s[F_BRD]) begin
      rgb_s = 8'hFF;
    end else begin
      rgb_s = BG_COLOR;
    end
  end

  // Output register: colour and delayed sync leave together.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_r <= 8'h00;
      de_r  <= 1'b0;
      hs_r  <= ~HSPP;
      vs_r  <= ~VSPP;
    end else begin
      rgb_r <= rgb_s;
      de_r  <= tap_s[F_DE];
      hs_r  <= tap_s[F_HS];
      vs_r  <= tap_s[F_VS];
    end
  end

  assign frame_start_s = (hdata == {WIDTH{1'b0}}) && (vdata == {WIDTH{1'b0}});

  // Buffer swap, taken only on the first pixel of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_sel_r  <= 1'b0;
      swap_ack_r <= 1'b0;
    end else if (frame_start_s && swap_req) begin
      buf_sel_r  <= ~buf_sel_r;
      swap_ack_r <= 1'b1;
    end else begin
      swap_ack_r <= 1'b0;
    end
  end

  assign mem_addr  = mem_addr_r;
  assign buf_sel   = buf_sel_r;
  assign swap_ack  = swap_ack_r;
  assign hsync_out = hs_r;
  assign vsync_out = vs_r;
  assign de_out    = de_r;
  assign red       = rgb_r[7:5];
  assign green     = rgb_r[4:2];
  assign blue      = rgb_r[1:0];

endmodule

// File: tb/tb_vga_image_overlay.sv
// Directed bench for vga_image_overlay: one instance with MEM_LAT=1 and one
// with MEM_LAT=2, driven in parallel, each with its own BRAM model.
module tb_vga_image_overlay;

  localparam int          L1       = 3;
  localparam int          L2       = 4;
  localparam logic [10:0] IDLE_OUT = 11'd0; // {de,hs,vs,rgb} inactive, HSPP=VSPP=1

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] hdata;
  logic [11:0] vdata;
  logic        de_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        swap_req;

  logic [10:0] mem_addr1, mem_addr2;
  logic [7:0]  rdata1, rdata2, rdata2_a;
  logic        swap_ack1, swap_ack2, buf_sel1, buf_sel2;
  logic        hs_out1, hs_out2, vs_out1, vs_out2, de_out1, de_out2;
  logic [2:0]  red1, red2, green1, green2;
  logic [1:0]  blue1, blue2;

  logic [7:0]  mem [2048];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          model_buf;
  bit          model_ack;
  logic [10:0] q1 [$];
  logic [10:0] q2 [$];
  logic [4:0]  lat1_exp;
  logic [4:0]  lat2_exp;
  int          rows [12];

  always #5 clk = ~clk;

  vga_image_overlay #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .hdata(hdata), .vdata(vdata), .de_in(de_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mem_addr(mem_addr1),
    .mem_rdata(rdata1), .swap_req(swap_req), .swap_ack(swap_ack1),
    .buf_sel(buf_sel1), .hsync_out(hs_out1), .vsync_out(vs_out1),
    .de_out(de_out1), .red(red1), .green(green1), .blue(blue1)
  );

  vga_image_overlay #(.MEM_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .hdata(hdata), .vdata(vdata), .de_in(de_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mem_addr(mem_addr2),
    .mem_rdata(rdata2), .swap_req(swap_req), .swap_ack(swap_ack2),
    .buf_sel(buf_sel2), .hsync_out(hs_out2), .vsync_out(vs_out2),
    .de_out(de_out2), .red(red2), .green(green2), .blue(blue2)
  );

  // BRAM models: one-cycle and two-cycle read latency.
  always @(posedge clk) begin
    rdata1   <= mem[mem_addr1];
    rdata2_a <= mem[mem_addr2];
    rdata2   <= rdata2_a;
  end

  // Checker image; the two buffers hold different grey levels.
  function automatic logic [7:0] img(bit b, int r, int c);
    if (((r + c) % 2) == 0) return b ? 8'hFF : 8'hA0;
    else                    return b ? 8'h5C : 8'h24;
  endfunction

  function automatic bit in_win(int h, int v);
    return (h >= 100) && (h < 324) && (v >= 50) && (v < 274);
  endfunction

  function automatic logic [10:0] ref_addr(int h, int v, bit b);
    if (in_win(h, v)) return {b, 10'(((v - 50) / 8) * 28 + (h - 100) / 8)};
    else              return {b, 10'd0};
  endfunction

  function automatic logic [10:0] ref_out(int h, int v, bit de, bit hs, bit vs, bit b);
    logic [7:0] p;
    logic [7:0] rgb;
    bit         brd;
    brd = (((h == 99) || (h == 324)) && (v >= 49) && (v <= 274)) ||
          (((v == 49) || (v == 274)) && (h >= 99) && (h <= 324));
    if (!de) rgb = 8'h00;
    else if (in_win(h, v)) begin
      p   = img(b, (v - 50) / 8, (h - 100) / 8);
      rgb = {p[7:5], p[7:5], p[7:6]};
    end
    else if (brd) rgb = 8'hFF;
    else rgb = 8'h00;
    return {de, hs, vs, rgb};
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one pixel cycle, advance the clock, and score both instances.
  task automatic drive(int h, int v, bit de, bit hs, bit vs, bit sreq, bit r);
    logic [10:0] exp_pix;
    logic [10:0] exp_addr;
    rst      = r;
    hdata    = 12'(h);
    vdata    = 12'(v);
    de_in    = de;
    hsync_in = hs;
    vsync_in = vs;
    swap_req = sreq;
    exp_pix  = ref_out(h, v, de, hs, vs, model_buf);
    exp_addr = r ? 11'd0 : ref_addr(h, v, model_buf);
    if (r) begin
      model_buf = 1'b0;
      model_ack = 1'b0;
    end else if (h == 0 && v == 0 && sreq) begin
      model_buf = ~model_buf;
      model_ack = 1'b1;
    end else begin
      model_ack = 1'b0;
    end
    @(posedge clk);
    #1;
    check_eq("addr1", mem_addr1, exp_addr);
    check_eq("addr2", mem_addr2, exp_addr);
    check_eq("swap1", {buf_sel1, swap_ack1}, {model_buf, model_ack});
    check_eq("swap2", {buf_sel2, swap_ack2}, {model_buf, model_ack});
    if (r) begin
      q1.delete();
      q2.delete();
      repeat (L1 - 1) q1.push_back(IDLE_OUT);
      repeat (L2 - 1) q2.push_back(IDLE_OUT);
      check_eq("pix1", {de_out1, hs_out1, vs_out1, red1, green1, blue1}, IDLE_OUT);
      check_eq("pix2", {de_out2, hs_out2, vs_out2, red2, green2, blue2}, IDLE_OUT);
    end else begin
      q1.push_back(exp_pix);
      q2.push_back(exp_pix);
      if (q1.size() == L1) check_eq("pix1", {de_out1, hs_out1, vs_out1, red1, green1, blue1}, q1.pop_front());
      if (q2.size() == L2) check_eq("pix2", {de_out2, hs_out2, vs_out2, red2, green2, blue2}, q2.pop_front());
    end
  endtask

  // Blank, non-frame-start filler cycle.
  task automatic idle();
    drive(0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 8'h00;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 784; i++) mem[b * 1024 + i] = img(b[0], i / 28, i % 28);
    model_buf = 1'b0;
    model_ack = 1'b0;
    lat1_exp  = 5'b00100;
    lat2_exp  = 5'b01000;
    rows      = '{48, 49, 50, 51, 57, 58, 100, 150, 273, 274, 275, 276};

    // Power-on reset.
    repeat (3) drive(10, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Latency: single-cycle hsync pulse.
    drive(500, 10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) drive(500 + k, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("lat1", hs_out1, lat1_exp[k]);
      check_eq("lat2", hs_out2, lat2_exp[k]);
    end

    // Addressing.
    drive(147, 66, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("addr_147_66", mem_addr1, 11'd61);
    drive(323, 273, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("addr_323_273", mem_addr1, 11'd783);
    drive(324, 273, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("addr_324_273", mem_addr1, 11'd0);

    // Colour: image pixel, border, background, blanking.
    drive(100, 50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); idle(); idle();
    check_eq("rgb_img", {red1, green1, blue1}, 8'hB6);
    drive(99, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); idle(); idle();
    check_eq("rgb_border", {red1, green1, blue1}, 8'hFF);
    drive(400, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); idle(); idle();
    check_eq("rgb_bg", {red1, green1, blue1}, 8'h00);
    drive(100, 50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); idle(); idle();
    check_eq("rgb_blank", {de_out1, red1, green1, blue1}, 9'h000);

    // Swap: ignored mid-frame, taken at frame start, repeated while held.
    for (int k = 0; k < 3; k++) begin
      drive(300 + k, 200, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("swap_mid", {buf_sel1, swap_ack1}, 2'b00);
    end
    drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("swap_take", {buf_sel1, swap_ack1}, 2'b11);
    drive(1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("swap_hold", {buf_sel1, swap_ack1}, 2'b10);
    drive(2, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("swap_again", {buf_sel1, swap_ack1}, 2'b01);
    drive(1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("swap_done", {buf_sel1, swap_ack1}, 2'b00);

    // Mid-frame reset with buffer 1 displayed and de/sync active.
    drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("pre_rst_buf", buf_sel1, 1'b1);
    for (int k = 0; k < 4; k++) drive(150 + k, 60, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) drive(154 + k, 60, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("rst_rgb", {red1, green1, blue1}, 8'h00);
    check_eq("rst_de", de_out1, 1'b0);
    check_eq("rst_sync", {hs_out1, vs_out1}, 2'b00);
    check_eq("rst_buf", {buf_sel1, swap_ack1}, 2'b00);
    drive(100, 50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_refill", de_out1, 1'b0);
    drive(101, 50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(102, 50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_first_pix", {de_out1, red1, green1, blue1}, 9'h1B6);

    // Scoreboard over two frames; the second one swaps to buffer 1.
    for (int f = 0; f < 2; f++) begin
      drive(0, 0, 1'b0, 1'b0, 1'b1, f == 1, 1'b0);
      foreach (rows[ri]) begin
        for (int h = 96; h <= 330; h++)
          drive(h, rows[ri], !(h >= 200 && h <= 203), h >= 326, rows[ri] == 49, 1'b0, 1'b0);
      end
    end
    for (int k = 0; k < 4; k++) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
